// File: rtl/phivers_dmem_arbiter.sv
// Shares one single-port data memory between the RS5 data interface and the
// DMNI DMA port. DMA has priority, bounded by MAX_BURST grants while the CPU waits.
module phivers_dmem_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_req_i,
  input  logic [3:0]            cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [31:0]           cpu_data_i,
  output logic                  cpu_stall_o,
  output logic [31:0]           cpu_data_o,
  input  logic                  dma_req_i,
  input  logic [3:0]            dma_we_i,
  input  logic [ADDR_WIDTH-1:0] dma_addr_i,
  input  logic [31:0]           dma_data_i,
  output logic                  dma_gnt_o,
  output logic [31:0]           dma_data_o,
  output logic                  dma_rvalid_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val >= BurstMax) ? BurstMax : val + 8'd1;
  endfunction

  logic [7:0]  burst_q, burst_d;
  owner_e      rd_owner_q, rd_owner_d;
  logic [31:0] cpu_hold_q;
  logic        cpu_gnt, dma_gnt, burst_full;

  always_comb begin
    burst_full = (burst_q == BurstMax);
    dma_gnt    = rst_ni && dma_req_i && !(cpu_req_i && burst_full);
    cpu_gnt    = rst_ni && cpu_req_i && !dma_gnt;
  end

  always_comb begin
    mem_en_o   = cpu_gnt | dma_gnt;
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (dma_gnt) begin
      mem_we_o   = dma_we_i;
      mem_addr_o = dma_addr_i;
      mem_data_o = dma_data_i;
    end else if (cpu_gnt) begin
      mem_we_o   = cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_data_o = cpu_data_i;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (!cpu_req_i || cpu_gnt) begin
      burst_d = '0;
    end else if (dma_gnt) begin
      burst_d = sat_inc(burst_q);
    end

    rd_owner_d = OWN_NONE;
    if (cpu_gnt && cpu_we_i == 4'h0) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && dma_we_i == 4'h0) begin
      rd_owner_d = OWN_DMA;
    end
  end

  // Registered state: burst counter, owner of the read in flight, CPU read hold
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      burst_q    <= '0;
      rd_owner_q <= OWN_NONE;
      cpu_hold_q <= '0;
    end else begin
      burst_q    <= burst_d;
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OWN_CPU) begin
        cpu_hold_q <= mem_data_i;
      end
    end
  end

  // A read in flight when reset asserts must not produce a DMA response.
  assign dma_rvalid_o = rst_ni && (rd_owner_q == OWN_DMA);
  assign dma_data_o   = mem_data_i;
  assign dma_gnt_o    = dma_gnt;
  assign cpu_stall_o  = !rst_ni || (cpu_req_i && !cpu_gnt);
  assign cpu_data_o   = (rd_owner_q == OWN_CPU) ? mem_data_i : cpu_hold_q;

endmodule

// File: doc/phivers_dmem_arbiter.md
# phivers_dmem_arbiter

Single-port data-memory arbiter for a Phivers PE. It shares one data-memory port between the RS5 data interface and the DMNI DMA port. When the DMNI wins a cycle, the CPU is stalled through the core's `stall` input. Read data returns one cycle after the access and is steered back to whichever requester issued that access. A bounded-burst policy gives the DMA priority while guaranteeing the CPU forward progress.

## Interface
Parameters:
- `ADDR_WIDTH`, 24: width of every address port.
- `MAX_BURST`, 16: maximum consecutive DMA grants while a CPU request is pending; range 1..255.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. **Synchronous, active-low.**
- `cpu_req_i`, in, 1: CPU data access request; held until granted.
- `cpu_we_i`, in, 4: CPU byte write enables; 0 means read.
- `cpu_addr_i`, in, ADDR_WIDTH: CPU address.
- `cpu_data_i`, in, 32: CPU write data.
- `cpu_stall_o`, out, 1: stalls the core.
- `cpu_data_o`, out, 32: CPU read data.
- `dma_req_i`, in, 1: DMA access request.
- `dma_we_i`, in, 4: DMA byte write enables.
- `dma_addr_i`, in, ADDR_WIDTH: DMA address.
- `dma_data_i`, in, 32: DMA write data.
- `dma_gnt_o`, out, 1: DMA access accepted this cycle.
- `dma_data_o`, out, 32: DMA read data.
- `dma_rvalid_o`, out, 1: `dma_data_o` valid.
- `mem_en_o`, out, 1: memory enable.
- `mem_we_o`, out, 4: memory byte write enables.
- `mem_addr_o`, out, ADDR_WIDTH: memory address.
- `mem_data_o`, out, 32: memory write data.
- `mem_data_i`, in, 32: memory read data, one-cycle latency.

## Operation
Grant logic:
- Grants are combinational from the request inputs and the registered `burst_q`.
- `dma_gnt = dma_req_i && !(cpu_req_i && burst_q == MAX_BURST)`.
- `cpu_gnt = cpu_req_i && !dma_gnt`.
- Exactly one of `cpu_gnt`/`dma_gnt` is high when any request is high; neither is high otherwise.

Memory port:
- `mem_en_o = cpu_gnt | dma_gnt`.
- `mem_we_o`, `mem_addr_o` and `mem_data_o` come from the granted requester.
- With no grant these three outputs are 0.

Stall and grant outputs:
- `cpu_stall_o = cpu_req_i && !cpu_gnt`.
- `dma_gnt_o = dma_gnt`.

Burst counter `burst_q` (8 bits):
- A cycle with `dma_gnt && cpu_req_i` increments it, saturating at MAX_BURST.
- A cycle with `cpu_gnt` clears it.
- A cycle where `cpu_req_i` is low clears it.

Read-return tracking (registered `rd_owner_q` ∈ {NONE, CPU, DMA}):
- Set to CPU on `cpu_gnt && cpu_we_i == 0`.
- Set to DMA on `dma_gnt && dma_we_i == 0`.
- Set to NONE otherwise, including on any write.

DMA read return:
- `dma_data_o = mem_data_i`.
- `dma_rvalid_o = (rd_owner_q == DMA)`.

CPU read return:
- When `rd_owner_q == CPU`, `cpu_data_o = mem_data_i`, and `mem_data_i` is captured into `cpu_hold_q`.
- Otherwise `cpu_data_o = cpu_hold_q`. This keeps CPU read data stable while the core is stalled after a read because of a following DMA burst.

Writes:
- No response is returned for writes.
- A write completes in its grant cycle.

Reset (`rst_ni` low at a clock edge):
- `burst_q = 0`, `rd_owner_q = NONE`, `cpu_hold_q = 0`.
- While `rst_ni` is low, both grants are forced to 0, `mem_en_o = 0` and `cpu_stall_o = 1`.
- An access in flight when reset is asserted is dropped: no `dma_rvalid_o` follows.

## Timing
Reset values of outputs:
- `cpu_stall_o = 1`; all other outputs = 0.
- `dma_data_o` and `cpu_data_o` follow `mem_data_i` / `cpu_hold_q` per the rules above.

Latency:
- Grant: 0 cycles, same cycle as the request.
- Read data: exactly 1 cycle after the grant, for both requesters.

CPU wait bound:
- With DMA requesting continuously, the CPU waits at most MAX_BURST cycles.
- After a forced CPU cycle, the DMA is granted again the next cycle.

Handshake rules:
- DMA: a request not granted in a cycle must be held stable by the DMNI until `dma_gnt_o`.
- CPU: held stable by the core while `cpu_stall_o` is high.

Simultaneous events:
- DMA read and CPU read requested in the same cycle with `burst_q < MAX_BURST`: DMA is served first; the CPU is granted on the first cycle without a DMA grant.
- A back-to-back DMA read and CPU read produce consecutive returns with no bubble.

Counter boundary:
- `burst_q` never exceeds MAX_BURST.
- MAX_BURST = 1 alternates DMA/CPU under full contention.

## Test plan
- **Reset hold:** `rst_ni` = 0 for 3 cycles with both requests high → `mem_en_o` = 0, `dma_gnt_o` = 0 and `cpu_stall_o` = 1 throughout; first cycle after release grants DMA.
- **Solo CPU read:** CPU-only read of 0x000040, memory returns 0xDEADBEEF → `cpu_stall_o` = 0; `cpu_data_o` = 0xDEADBEEF the next cycle and held until the next CPU read.
- **Starvation bound:** continuous DMA reads plus a CPU read, MAX_BURST = 16 → 16 DMA grants, CPU granted in cycle 17, `dma_rvalid_o` low in cycle 18, DMA regranted in cycle 18.
- **Mixed writes:** DMA write of 0x12345678 (we = 0xF) then a DMA read of the same address → write produces no rvalid; read returns 0x12345678 with `dma_rvalid_o` = 1 one cycle after its grant.
- **Reset mid-read:** DMA read granted, `rst_ni` low on the next edge → no `dma_rvalid_o`; `burst_q` = 0 afterwards.
- **MAX_BURST = 1 full contention:** grants strictly alternate DMA, CPU, DMA, CPU over 8 cycles.
